// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter
// Shares the Z80 system bus between the CPU and NREQ DMA masters. It takes the bus
// from the CPU with busrq_n/busak_n, then grants it to one master in round-robin
// order. A grant is revoked after MAX_HOLD cycles. The CPU then keeps the bus for at
// least CPU_MIN cycles before the next request. All state advances only when i_cen=1.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   i_cen       clock enable, same strobe as the CPU core
//   i_dma_req   level request per master, held high until the master is done
//   o_dma_gnt   one-hot grant; a master may drive the bus only while its bit is high
//   o_busrq_n   bus request to the CPU
//   i_busak_n   bus acknowledge from the CPU
//   o_owner     index of the last or current granted master
//   o_cpu_owns  high while the CPU drives the bus (IDLE/ARM)
//   o_preempt   one-cen-cycle pulse when MAX_HOLD revokes a grant
module z80_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 64,
  parameter int CPU_MIN  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_cen,
  input  logic [NREQ-1:0] i_dma_req,
  output logic [NREQ-1:0] o_dma_gnt,
  output logic            o_busrq_n,
  input  logic            i_busak_n,
  output logic [2:0]      o_owner,
  output logic            o_cpu_owns,
  output logic            o_preempt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int CW = (CPU_MIN > 0) ? $clog2(CPU_MIN + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX    = IW'(NREQ - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(MAX_HOLD);
  localparam logic [CW-1:0] CPU_MIN_CNT = CW'(CPU_MIN);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    GRANT,
    REL,
    WAITC
  } state_t;

  state_t          r_state;
  logic            r_busrq_n;
  logic [NREQ-1:0] r_dmaGnt;
  logic [2:0]      r_owner;
  logic            r_cpuOwns;
  logic            r_preempt;
  logic [IW-1:0]   r_rrPtr;
  logic [IW-1:0]   r_winner;
  logic [HW-1:0]   r_holdCnt;
  logic [CW-1:0]   r_cpuCnt;

  logic [IW-1:0]   w_winner;
  logic [NREQ-1:0] w_winnerOneHot;
  logic [2:0]      w_winnerExt;
  logic [IW-1:0]   w_nextPtr;
  logic            w_winnerReq;

  // Scan requesters starting at the round-robin pointer and wrap past NREQ-1.
  // The first active requester found wins.
  always_comb begin
    int            idx;
    logic [IW-1:0] idxBits;
    logic          found;
    idx      = 0;
    idxBits  = '0;
    found    = 1'b0;
    w_winner = r_rrPtr;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_rrPtr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idxBits = idx[IW-1:0];
      if (!found && i_dma_req[idxBits]) begin
        w_winner = idxBits;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_winnerOneHot           = '0;
    w_winnerOneHot[r_winner] = 1'b1;
    w_winnerExt              = '0;
    w_winnerExt[IW-1:0]      = r_winner;
  end

  assign w_winnerReq = i_dma_req[r_winner];
  assign w_nextPtr   = (r_winner == LAST_IDX) ? '0 : r_winner + IW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_busrq_n <= 1'b1;
      r_dmaGnt  <= '0;
      r_owner   <= '0;
      r_cpuOwns <= 1'b1;
      r_preempt <= 1'b0;
      r_rrPtr   <= '0;
      r_winner  <= '0;
      r_holdCnt <= '0;
      r_cpuCnt  <= '0;
    end else if (i_cen) begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_cpuCnt < CPU_MIN_CNT) r_cpuCnt <= r_cpuCnt + CW'(1);
          if (r_cpuCnt >= CPU_MIN_CNT && i_busak_n && |i_dma_req) begin
            r_winner  <= w_winner;
            r_busrq_n <= 1'b0;
            r_state   <= ARM;
          end
        end
        ARM: begin
          // The request is already committed to the CPU. If the winner has gone away,
          // still step through REL so that busrq_n is released cleanly.
          if (!i_busak_n) begin
            r_cpuOwns <= 1'b0;
            if (w_winnerReq) begin
              r_dmaGnt  <= w_winnerOneHot;
              r_owner   <= w_winnerExt;
              r_holdCnt <= HW'(1);
              r_state   <= GRANT;
            end else begin
              r_state <= REL;
            end
          end
        end
        GRANT: begin
          if (i_busak_n) begin
            // The CPU took the bus back without being asked. Get off the bus at once.
            r_dmaGnt  <= '0;
            r_busrq_n <= 1'b1;
            r_rrPtr   <= w_nextPtr;
            r_state   <= WAITC;
          end else if (!w_winnerReq || r_holdCnt == HOLD_MAX) begin
            r_dmaGnt  <= '0;
            r_rrPtr   <= w_nextPtr;
            r_preempt <= w_winnerReq;
            r_state   <= REL;
          end else begin
            r_holdCnt <= r_holdCnt + HW'(1);
          end
        end
        REL: begin
          r_busrq_n <= 1'b1;
          r_state   <= WAITC;
        end
        WAITC: begin
          if (i_busak_n) begin
            r_cpuOwns <= 1'b1;
            r_cpuCnt  <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_dma_gnt  = r_dmaGnt;
  assign o_busrq_n  = r_busrq_n;
  assign o_owner    = r_owner;
  assign o_cpu_owns = r_cpuOwns;
  assign o_preempt  = r_preempt;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter
// Self-checking bench for z80_bus_arbiter (NREQ=2, MAX_HOLD=64, CPU_MIN=4).
// A table of cycle vectors drives req/busak_n directly and gives the expected outputs
// after each cen step. Hand-written sequences use a small CPU model for round-robin
// with preemption, the hold-limit boundary, async reset mid-grant and a CPU that
// breaks protocol. The table and the round-robin run are repeated with cen 1-in-4.
module tb_z80_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic       cen;
  logic [1:0] dmaReq;
  logic       busakN;
  logic [1:0] dmaGnt;
  logic       busrqN;
  logic [2:0] owner;
  logic       cpuOwns;
  logic       preempt;

  int tests    = 0;
  int failures = 0;
  bit cpuAuto  = 1'b0;
  int ackDelay = 3;
  int ackCnt   = 0;

  z80_bus_arbiter #(.NREQ(2), .MAX_HOLD(64), .CPU_MIN(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_cen      (cen),
    .i_dma_req  (dmaReq),
    .o_dma_gnt  (dmaGnt),
    .o_busrq_n  (busrqN),
    .i_busak_n  (busakN),
    .o_owner    (owner),
    .o_cpu_owns (cpuOwns),
    .o_preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: rst, n, req, busak, expBusrq, expGnt, expOwner, expCpu, cpuCare, expPre
  typedef struct {
    bit         rst;
    int         n;
    logic [1:0] req;
    logic       busak;
    logic       expBusrq;
    logic [1:0] expGnt;
    logic [2:0] expOwner;
    logic       expCpu;
    bit         cpuCare;
    logic       expPre;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic busak);
    dmaReq = req;
    busakN = busak;
  endtask

  // One cen cycle: a single enabled edge followed by ratio-1 disabled clocks.
  // Outputs are sampled on the falling edge. The CPU model then reacts for the next step.
  task automatic stepCen(input int ratio);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    repeat (ratio - 1) @(negedge clk);
    checkOutput("gnt while busak_n high", {7'd0, (dmaGnt != 2'b00) && busakN}, 8'd0);
    if (cpuAuto) begin
      if (!busrqN && busakN) begin
        ackCnt++;
        if (ackCnt >= ackDelay) begin
          busakN = 1'b0;
          ackCnt = 0;
        end
      end else if (busrqN && !busakN) begin
        busakN = 1'b1;
        ackCnt = 0;
      end else begin
        ackCnt = 0;
      end
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    cen     = 1'b0;
    applyStimulus(2'b00, 1'b1);
    ackCnt  = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic runTable(input int ratio);
    cpuAuto = 1'b0;
    for (int r = 0; r < NV; r++) begin
      if (tbl[r].rst) doReset();
      for (int k = 0; k < tbl[r].n; k++) begin
        applyStimulus(tbl[r].req, tbl[r].busak);
        stepCen(ratio);
        checkOutput($sformatf("vec%0d.%0d/r%0d busrq_n", r, k, ratio), {7'd0, busrqN}, {7'd0, tbl[r].expBusrq});
        checkOutput($sformatf("vec%0d.%0d/r%0d dma_gnt", r, k, ratio), {6'd0, dmaGnt}, {6'd0, tbl[r].expGnt});
        checkOutput($sformatf("vec%0d.%0d/r%0d owner", r, k, ratio), {5'd0, owner}, {5'd0, tbl[r].expOwner});
        if (tbl[r].cpuCare)
          checkOutput($sformatf("vec%0d.%0d/r%0d cpu_owns", r, k, ratio), {7'd0, cpuOwns}, {7'd0, tbl[r].expCpu});
        checkOutput($sformatf("vec%0d.%0d/r%0d preempt", r, k, ratio), {7'd0, preempt}, {7'd0, tbl[r].expPre});
      end
    end
  endtask

  // Both masters request continuously. Expect three grants 01,10,01, each exactly
  // 64 cen cycles, each ending in a one-cycle preempt, with at least CPU_MIN CPU
  // cycles before every bus request.
  task automatic runRoundRobin(input int ratio);
    logic [1:0] expSeq [3];
    logic [1:0] prevGnt;
    logic       prevPre;
    logic       prevBusrq;
    int         started;
    int         ended;
    int         len;
    int         idleRun;
    int         preCnt;
    expSeq    = '{2'b01, 2'b10, 2'b01};
    prevGnt   = 2'b00;
    prevPre   = 1'b0;
    prevBusrq = 1'b1;
    started   = 0;
    ended     = 0;
    len       = 0;
    idleRun   = 0;
    preCnt    = 0;
    doReset();
    cpuAuto  = 1'b1;
    ackDelay = 2;
    dmaReq   = 2'b11;
    for (int c = 0; c < 600; c++) begin
      stepCen(ratio);
      if (prevGnt == 2'b00 && dmaGnt != 2'b00) begin
        if (started < 3)
          checkOutput($sformatf("rr/r%0d grant%0d value", ratio, started), {6'd0, dmaGnt}, {6'd0, expSeq[started]});
        started++;
        len = 1;
      end else if (dmaGnt != 2'b00) begin
        len++;
      end
      if (prevGnt != 2'b00 && dmaGnt == 2'b00) begin
        checkOutput($sformatf("rr/r%0d grant%0d length", ratio, ended), len[7:0], 8'd64);
        checkOutput($sformatf("rr/r%0d grant%0d preempt", ratio, ended), {7'd0, preempt}, 8'd1);
        ended++;
      end
      if (prevPre) checkOutput($sformatf("rr/r%0d preempt width", ratio), {7'd0, preempt}, 8'd0);
      if (preempt) preCnt++;
      if (busrqN && cpuOwns) begin
        idleRun++;
      end else begin
        if (prevBusrq && !busrqN)
          checkOutput($sformatf("rr/r%0d cpu window", ratio), {7'd0, idleRun >= 4}, 8'd1);
        idleRun = 0;
      end
      prevGnt   = dmaGnt;
      prevPre   = preempt;
      prevBusrq = busrqN;
      if (ended == 3) break;
    end
    checkOutput($sformatf("rr/r%0d grants completed", ratio), ended[7:0], 8'd3);
    checkOutput($sformatf("rr/r%0d preempt count", ratio), preCnt[7:0], 8'd3);
    cpuAuto = 1'b0;
  endtask

  task automatic waitGnt(input string tag, input logic [1:0] want);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      stepCen(1);
      if (dmaGnt != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, " grant seen"}, {7'd0, seen}, 8'd1);
    checkOutput({tag, " grant value"}, {6'd0, dmaGnt}, {6'd0, want});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single master round, cycle by cycle. The CPU acks 3 cycles after busrq_n.
    tbl[0]  = '{1, 4,  2'b01, 1, 1, 2'b00, 3'd0, 1, 1, 0};
    tbl[1]  = '{0, 1,  2'b01, 1, 0, 2'b00, 3'd0, 1, 1, 0};
    tbl[2]  = '{0, 2,  2'b01, 1, 0, 2'b00, 3'd0, 1, 1, 0};
    tbl[3]  = '{0, 10, 2'b01, 0, 0, 2'b01, 3'd0, 0, 1, 0};
    tbl[4]  = '{0, 1,  2'b00, 0, 0, 2'b00, 3'd0, 0, 1, 0};
    tbl[5]  = '{0, 1,  2'b00, 0, 1, 2'b00, 3'd0, 0, 1, 0};
    tbl[6]  = '{0, 1,  2'b00, 1, 1, 2'b00, 3'd0, 1, 1, 0};
    tbl[7]  = '{0, 3,  2'b00, 1, 1, 2'b00, 3'd0, 1, 1, 0};
    // Fourth IDLE cycle after re-entry, then master 1 wins (rr_ptr=1), owner=1.
    tbl[8]  = '{0, 1,  2'b10, 1, 1, 2'b00, 3'd0, 1, 1, 0};
    tbl[9]  = '{0, 1,  2'b10, 1, 0, 2'b00, 3'd0, 1, 1, 0};
    tbl[10] = '{0, 1,  2'b10, 0, 0, 2'b10, 3'd1, 0, 1, 0};
    tbl[11] = '{0, 2,  2'b10, 0, 0, 2'b10, 3'd1, 0, 1, 0};
    tbl[12] = '{0, 1,  2'b00, 0, 0, 2'b00, 3'd1, 0, 1, 0};
    tbl[13] = '{0, 1,  2'b00, 0, 1, 2'b00, 3'd1, 0, 1, 0};
    tbl[14] = '{0, 1,  2'b00, 1, 1, 2'b00, 3'd1, 1, 1, 0};
    // Request withdrawn during ARM: no grant; busrq_n is released after REL.
    tbl[15] = '{1, 4,  2'b10, 1, 1, 2'b00, 3'd0, 1, 1, 0};
    tbl[16] = '{0, 1,  2'b10, 1, 0, 2'b00, 3'd0, 1, 1, 0};
    tbl[17] = '{0, 1,  2'b00, 1, 0, 2'b00, 3'd0, 1, 1, 0};
    tbl[18] = '{0, 1,  2'b00, 0, 0, 2'b00, 3'd0, 0, 0, 0};
    tbl[19] = '{0, 1,  2'b00, 0, 1, 2'b00, 3'd0, 0, 0, 0};
    tbl[20] = '{0, 1,  2'b00, 1, 1, 2'b00, 3'd0, 1, 1, 0};

    reset_n = 1'b0;
    cen     = 1'b0;
    applyStimulus(2'b00, 1'b1);
    doReset();
    checkOutput("reset busrq_n", {7'd0, busrqN}, 8'd1);
    checkOutput("reset dma_gnt", {6'd0, dmaGnt}, 8'd0);
    checkOutput("reset owner", {5'd0, owner}, 8'd0);
    checkOutput("reset cpu_owns", {7'd0, cpuOwns}, 8'd1);
    checkOutput("reset preempt", {7'd0, preempt}, 8'd0);

    runTable(1);
    runTable(4);
    runRoundRobin(1);
    runRoundRobin(4);

    // Request dropped on the very cycle hold_cnt reaches MAX_HOLD: release without preempt.
    doReset();
    cpuAuto  = 1'b1;
    ackDelay = 1;
    dmaReq   = 2'b01;
    waitGnt("hold", 2'b01);
    repeat (63) stepCen(1);
    checkOutput("hold gnt at 64th cycle", {6'd0, dmaGnt}, 8'h01);
    dmaReq = 2'b00;
    stepCen(1);
    checkOutput("hold release gnt", {6'd0, dmaGnt}, 8'h00);
    checkOutput("hold release preempt", {7'd0, preempt}, 8'd0);

    // Asynchronous reset during master 1's grant. Afterwards rr_ptr=0, so master 0 wins.
    doReset();
    cpuAuto = 1'b1;
    dmaReq  = 2'b01;
    waitGnt("areset first", 2'b01);
    dmaReq = 2'b10;
    stepCen(1);
    checkOutput("areset first release", {6'd0, dmaGnt}, 8'h00);
    waitGnt("areset second", 2'b10);
    checkOutput("areset second owner", {5'd0, owner}, 8'd1);
    repeat (2) stepCen(1);
    reset_n = 1'b0;
    #1;
    checkOutput("areset async gnt", {6'd0, dmaGnt}, 8'h00);
    checkOutput("areset async busrq_n", {7'd0, busrqN}, 8'd1);
    checkOutput("areset async cpu_owns", {7'd0, cpuOwns}, 8'd1);
    checkOutput("areset async owner", {5'd0, owner}, 8'd0);
    busakN = 1'b1;
    ackCnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dmaReq  = 2'b11;
    waitGnt("areset after", 2'b01);

    // The CPU raises busak_n during GRANT: the grant drops on that edge, then back to IDLE.
    doReset();
    cpuAuto = 1'b1;
    dmaReq  = 2'b01;
    waitGnt("cpu grab", 2'b01);
    repeat (3) stepCen(1);
    cpuAuto = 1'b0;
    busakN  = 1'b1;
    stepCen(1);
    checkOutput("cpu grab gnt drop", {6'd0, dmaGnt}, 8'h00);
    stepCen(1);
    checkOutput("cpu grab idle cpu_owns", {7'd0, cpuOwns}, 8'd1);
    checkOutput("cpu grab idle busrq_n", {7'd0, busrqN}, 8'd1);
    cpuAuto = 1'b1;
    waitGnt("cpu grab regrant", 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
